// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_serial_add_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Requester-side handshake and operand/result bus for the nibble-serial adder.
interface nibble_serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, op_a, op_b,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, op_a, op_b,
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/nibble_serial_add_ctrl_adder4bit_ci.sv
// Purely combinational 4-bit adder slice with carry in and carry out.
module adder4bit_ci (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock through a single shared
// 4-bit adder slice, LSB nibble first, with a start/busy/done handshake.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  nibble_serial_add_ctrl_if.slave  bus
);

  localparam int unsigned NIBBLES  = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [NIBBLE_W-1:0] a_nib, b_nib, slice_sum;
  logic                slice_cout;
  logic [WIDTH-1:0]    acc_new;
  logic                accept;

  always_comb begin
    a_nib   = '0;
    b_nib   = '0;
    acc_new = acc_q;
    for (int unsigned n = 0; n < NIBBLES; n++) begin
      if (idx_q == IDX_W'(n)) begin
        a_nib = a_q[n*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[n*NIBBLE_W +: NIBBLE_W];
        acc_new[n*NIBBLE_W +: NIBBLE_W] = slice_sum;
      end
    end
  end

  adder4bit_ci u_slice (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // New operands are taken only from IDLE or the DONE cycle; start during RUN is dropped.
  assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        acc_d   = acc_new;
        carry_d = slice_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
          sum_d   = acc_new;
          cout_d  = slice_cout;
        end
      end
      DONE: begin
        state_d = bus.start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d     = bus.op_a;
      b_d     = bus.op_b;
      idx_d   = '0;
      carry_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for nibble_serial_add_ctrl at WIDTH=4 and WIDTH=16.
module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  int   done_cnt16 = 0;
  int   dc;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl_if #(.WIDTH(4))  bus4 ();
  nibble_serial_add_ctrl_if #(.WIDTH(16)) bus16 ();

  nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) if (bus16.done) done_cnt16++;

  always @(negedge clk) begin
    if (mon_en) begin
      check("excl4",  32'(bus4.busy & bus4.done), 32'd0);
      check("excl16", 32'(bus16.busy & bus16.done), 32'd0);
    end
  end

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_sum, input logic exp_c);
    bus16.start = 1'b1;
    bus16.op_a  = a;
    bus16.op_b  = b;
    @(negedge clk);
    bus16.start = 1'b0;
    bus16.op_a  = ~a;
    bus16.op_b  = 16'h5A5A;
    for (int i = 1; i <= 4; i++) begin
      check({tag, "_busy"}, 32'(bus16.busy), 32'd1);
      check({tag, "_nodone"}, 32'(bus16.done), 32'd0);
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(bus16.done), 32'd1);
    check({tag, "_sum"}, 32'(bus16.sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(bus16.carry_out), 32'(exp_c));
    @(negedge clk);
    check({tag, "_done_low"}, 32'(bus16.done), 32'd0);
    check({tag, "_sum_held"}, 32'(bus16.sum), 32'(exp_sum));
  endtask

  initial begin
    reset = 1'b1;
    bus4.start = 1'b0;  bus4.op_a = '0;  bus4.op_b = '0;
    bus16.start = 1'b0; bus16.op_a = '0; bus16.op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy16", 32'(bus16.busy), 32'd0);
    check("rst_done16", 32'(bus16.done), 32'd0);
    check("rst_sum16",  32'(bus16.sum), 32'd0);
    check("rst_cout16", 32'(bus16.carry_out), 32'd0);
    check("rst_busy4",  32'(bus4.busy), 32'd0);
    check("rst_done4",  32'(bus4.done), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // WIDTH=4: 12 + 15 = 27 -> sum 11, carry 1, done two cycles after accept
    bus4.start = 1'b1; bus4.op_a = 4'd12; bus4.op_b = 4'd15;
    @(negedge clk);
    bus4.start = 1'b0; bus4.op_a = 4'd0; bus4.op_b = 4'd0;
    check("w4_busy", 32'(bus4.busy), 32'd1);
    check("w4_nodone", 32'(bus4.done), 32'd0);
    @(negedge clk);
    check("w4_done", 32'(bus4.done), 32'd1);
    check("w4_busy_low", 32'(bus4.busy), 32'd0);
    check("w4_sum", 32'(bus4.sum), 32'd11);
    check("w4_cout", 32'(bus4.carry_out), 32'd1);
    @(negedge clk);
    check("w4_done_low", 32'(bus4.done), 32'd0);
    check("w4_sum_held", 32'(bus4.sum), 32'd11);

    run16("t2", 16'h1234, 16'h4321, 16'h5555, 1'b0);
    run16("t3", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);

    // Start while busy is ignored
    dc = done_cnt16;
    bus16.start = 1'b1; bus16.op_a = 16'h0F0F; bus16.op_b = 16'h0101;
    @(negedge clk);
    bus16.start = 1'b0;
    check("t4_busy1", 32'(bus16.busy), 32'd1);
    @(negedge clk);
    bus16.start = 1'b1; bus16.op_a = 16'hFFFF; bus16.op_b = 16'hFFFF;
    check("t4_busy2", 32'(bus16.busy), 32'd1);
    @(negedge clk);
    bus16.start = 1'b0;
    check("t4_busy3", 32'(bus16.busy), 32'd1);
    @(negedge clk);
    check("t4_busy4", 32'(bus16.busy), 32'd1);
    @(negedge clk);
    check("t4_done", 32'(bus16.done), 32'd1);
    check("t4_sum", 32'(bus16.sum), 32'h1010);
    check("t4_cout", 32'(bus16.carry_out), 32'd0);
    repeat (6) @(negedge clk);
    check("t4_one_done", 32'(done_cnt16 - dc), 32'd1);

    // Back-to-back: new start in the done cycle
    bus16.start = 1'b1; bus16.op_a = 16'h8000; bus16.op_b = 16'h8001;
    @(negedge clk);
    bus16.start = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_done1", 32'(bus16.done), 32'd1);
    check("t5_sum1", 32'(bus16.sum), 32'h0001);
    check("t5_cout1", 32'(bus16.carry_out), 32'd1);
    bus16.start = 1'b1; bus16.op_a = 16'h0008; bus16.op_b = 16'h0003;
    @(negedge clk);
    bus16.start = 1'b0; bus16.op_a = 16'hFFFF; bus16.op_b = 16'hFFFF;
    for (int i = 1; i <= 4; i++) begin
      check("t5_busy", 32'(bus16.busy), 32'd1);
      check("t5_held", 32'(bus16.sum), 32'h0001);
      @(negedge clk);
    end
    check("t5_done2", 32'(bus16.done), 32'd1);
    check("t5_sum2", 32'(bus16.sum), 32'h000B);
    check("t5_cout2", 32'(bus16.carry_out), 32'd0);
    @(negedge clk);

    // Reset mid-RUN aborts the operation
    bus16.start = 1'b1; bus16.op_a = 16'h1111; bus16.op_b = 16'h2222;
    @(negedge clk);
    bus16.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t6_busy_pre", 32'(bus16.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_busy", 32'(bus16.busy), 32'd0);
    check("t6_done", 32'(bus16.done), 32'd0);
    check("t6_sum", 32'(bus16.sum), 32'd0);
    check("t6_cout", 32'(bus16.carry_out), 32'd0);
    dc = done_cnt16;
    repeat (8) @(negedge clk);
    check("t6_no_done", 32'(done_cnt16 - dc), 32'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
